// File: rtl/freq_sweep_analyzer_if.sv
// Result channel of the frequency sweep analyzer: one measured point per transfer.
// A point moves when result_valid and result_ready are both high on a rising clk edge; the master holds all result fields stable while valid waits for ready.
interface freq_sweep_analyzer_if #(
  parameter int WORD_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 32
);
  logic                           result_valid;
  logic                           result_ready;
  logic        [PERIOD_WIDTH-1:0] result_period;
  logic signed [WORD_WIDTH-1:0]   result_min;
  logic signed [WORD_WIDTH-1:0]   result_max;
  logic        [WORD_WIDTH:0]     result_p2p;
  logic                           result_empty;

  modport master (
    output result_valid, result_period, result_min, result_max, result_p2p, result_empty,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_period, result_min, result_max, result_p2p, result_empty,
    output result_ready
  );
endinterface

// File: rtl/freq_sweep_analyzer.sv
// Steps a sine generator through a range of periods and reports the min/max/peak-to-peak
// response of the device under test over a fixed number of sine turns at each period.
module freq_sweep_analyzer #(
  parameter int WORD_WIDTH    = 16,
  parameter int PERIOD_WIDTH  = 32,
  parameter int MEAS_TURNS    = 4,
  parameter int SETTLE_CYCLES = 4096,
  parameter int GAP_CYCLES    = 100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic        [PERIOD_WIDTH-1:0] period_start,
  input  logic        [PERIOD_WIDTH-1:0] period_step,
  input  logic        [PERIOD_WIDTH-1:0] period_stop,
  input  logic signed [WORD_WIDTH-1:0]   sample_in,
  input  logic                           sample_valid,
  output logic        [PERIOD_WIDTH-1:0] gen_period,
  output logic                           gen_run,
  output logic                           busy,
  output logic                           done,
  output logic        [2:0]              dbg_state,
  freq_sweep_analyzer_if.master          res
);

  localparam int WIN_W = PERIOD_WIDTH + 10 + $clog2(MEAS_TURNS) + 1;
  localparam logic [WIN_W-1:0] TURN_CLKS   = WIN_W'(MEAS_TURNS * 1024);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] GAP_LAST    = WIN_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    REPORT  = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t                         state;
  logic        [PERIOD_WIDTH-1:0] step_q;
  logic        [PERIOD_WIDTH-1:0] stop_q;
  logic        [WIN_W-1:0]        cnt;
  logic signed [WORD_WIDTH-1:0]   trk_min;
  logic signed [WORD_WIDTH-1:0]   trk_max;
  logic                           trk_empty;

  logic        [WIN_W-1:0]        win_last;
  logic signed [WORD_WIDTH-1:0]   min_nxt;
  logic signed [WORD_WIDTH-1:0]   max_nxt;
  logic                           empty_nxt;
  logic        [WORD_WIDTH:0]     p2p_nxt;
  logic        [PERIOD_WIDTH:0]   next_period;
  logic                           sweep_end;

  assign dbg_state = state;

  // Window length is a full-width product, so large periods never wrap the counter.
  assign win_last = WIN_W'(gen_period) * TURN_CLKS - WIN_W'(1);

  always_comb begin
    min_nxt   = trk_min;
    max_nxt   = trk_max;
    empty_nxt = trk_empty;
    if (sample_valid) begin
      if (trk_empty || sample_in < trk_min) min_nxt = sample_in;
      if (trk_empty || sample_in > trk_max) max_nxt = sample_in;
      empty_nxt = 1'b0;
    end
  end

  assign p2p_nxt     = {max_nxt[WORD_WIDTH-1], max_nxt} - {min_nxt[WORD_WIDTH-1], min_nxt};
  assign next_period = {1'b0, gen_period} + {1'b0, step_q};
  assign sweep_end   = (step_q == '0) || (next_period > {1'b0, stop_q}) || next_period[PERIOD_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      step_q            <= '0;
      stop_q            <= '0;
      cnt               <= '0;
      trk_min           <= '0;
      trk_max           <= '0;
      trk_empty         <= 1'b0;
      gen_period        <= '0;
      gen_run           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      res.result_valid  <= 1'b0;
      res.result_period <= '0;
      res.result_min    <= '0;
      res.result_max    <= '0;
      res.result_p2p    <= '0;
      res.result_empty  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step_q     <= period_step;
            stop_q     <= period_stop;
            gen_period <= (period_start == '0) ? PERIOD_WIDTH'(1) : period_start;
            gen_run    <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt       <= '0;
            trk_min   <= '0;
            trk_max   <= '0;
            trk_empty <= 1'b1;
            state     <= MEASURE;
          end else begin
            cnt <= cnt + WIN_W'(1);
          end
        end
        MEASURE: begin
          trk_min   <= min_nxt;
          trk_max   <= max_nxt;
          trk_empty <= empty_nxt;
          if (cnt == win_last) begin
            cnt               <= '0;
            res.result_valid  <= 1'b1;
            res.result_period <= gen_period;
            res.result_min    <= empty_nxt ? '0 : min_nxt;
            res.result_max    <= empty_nxt ? '0 : max_nxt;
            res.result_p2p    <= empty_nxt ? '0 : p2p_nxt;
            res.result_empty  <= empty_nxt;
            state             <= REPORT;
          end else begin
            cnt <= cnt + WIN_W'(1);
          end
        end
        REPORT: begin
          // Samples arriving while stalled here are deliberately ignored.
          if (res.result_ready) begin
            res.result_valid <= 1'b0;
            gen_run          <= 1'b0;
            cnt              <= '0;
            if (sweep_end) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gen_period <= next_period[PERIOD_WIDTH-1:0];
              state      <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt     <= '0;
            gen_run <= 1'b1;
            state   <= SETTLE;
          end else begin
            cnt <= cnt + WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sweep_analyzer.sv
// Randomized bench for freq_sweep_analyzer: a reference model plans each sweep's periods and
// folds the in-window samples into expected results that a monitor compares on every transfer.
module tb_freq_sweep_analyzer;

  localparam int WW = 16;
  localparam int PW = 8;
  localparam int MT = 1;
  localparam int SC = 64;
  localparam int GC = 10;
  localparam int RW = PW + 3 * WW + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic        [PW-1:0] period_start = '0;
  logic        [PW-1:0] period_step = '0;
  logic        [PW-1:0] period_stop = '0;
  logic signed [WW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic        [PW-1:0] gen_period;
  logic                 gen_run;
  logic                 busy;
  logic                 done;
  logic        [2:0]    dbg_state;

  freq_sweep_analyzer_if #(.WORD_WIDTH(WW), .PERIOD_WIDTH(PW)) res_if ();

  freq_sweep_analyzer #(
    .WORD_WIDTH   (WW),
    .PERIOD_WIDTH (PW),
    .MEAS_TURNS   (MT),
    .SETTLE_CYCLES(SC),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .period_start(period_start),
    .period_step (period_step),
    .period_stop (period_stop),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .gen_period  (gen_period),
    .gen_run     (gen_run),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state),
    .res         (res_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  int            per_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            mode = 0;        // 0 random, 1 bounded +-1000, 2 no valid, 3 extremes
  int            ready_mode = 0;  // 0 always ready, 1 random, 2 held low
  int            done_cnt = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic plan_sweep(input int s, input int st, input int sp);
    longint p;
    longint n;
    p = (s == 0) ? 1 : s;
    while (1) begin
      per_q.push_back(int'(p));
      if (st == 0) break;
      n = p + st;
      if (n > sp || n >= (longint'(1) << PW)) break;
      p = n;
    end
  endtask

  // ---------------- monitor / sample driver / model ----------------
  logic          prev_gr = 1'b0;
  logic          prev_rv = 1'b0;
  logic          active = 1'b0;
  logic          any = 1'b0;
  logic          stalled = 1'b0;
  logic          in_win;
  int            k = 0;
  int            win = 0;
  int            cur_p = 0;
  int            run_cnt = 0;
  int            gap_cnt = 0;
  int            idx = 0;
  int            tmin = 0;
  int            tmax = 0;
  int            v = 0;
  logic [RW-1:0] snap;
  logic [RW-1:0] cur_res;
  logic [RW-1:0] e;
  logic [PW-1:0] snap_gp;

  initial begin : port_proc
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       res_if.result_ready = 1'b1;
        1:       res_if.result_ready = 1'($urandom_range(0, 1));
        default: res_if.result_ready = 1'b0;
      endcase
      if (done) done_cnt++;

      // new point: generator released
      if (gen_run && !prev_gr) begin
        if (gap_cnt != 0) check("gap_len", gap_cnt, GC);
        gap_cnt = 0;
        if (per_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_point: got gen_period %0d, expected no further point", gen_period);
          active = 1'b0;
        end else begin
          cur_p  = per_q.pop_front();
          active = 1'b1;
          check("gen_period", gen_period, cur_p);
        end
        win = MT * 1024 * cur_p;
        k = 0;
        run_cnt = 0;
        any = 1'b0;
      end
      if (!gen_run) begin
        active  = 1'b0;
        gap_cnt = busy ? gap_cnt + 1 : 0;
      end
      if (gen_run && !res_if.result_valid) run_cnt++;
      if (res_if.result_valid && !prev_rv && active) check("window_len", run_cnt, SC + win);

      // result channel
      cur_res = {res_if.result_period, res_if.result_min, res_if.result_max,
                 res_if.result_p2p, res_if.result_empty};
      if (res_if.result_valid) begin
        if (stalled) begin
          check("hold_result", cur_res, snap);
          check("hold_gen_period", gen_period, snap_gp);
        end
        if (res_if.result_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got period %0d, expected no result", res_if.result_period);
          end else begin
            e = exp_q.pop_front();
            check("res_period", res_if.result_period, e[RW-1 -: PW]);
            check("res_min", res_if.result_min, $signed(e[3*WW+1 -: WW]));
            check("res_max", res_if.result_max, $signed(e[2*WW+1 -: WW]));
            check("res_p2p", res_if.result_p2p, e[WW+1 -: WW+1]);
            check("res_empty", res_if.result_empty, e[0]);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          snap    = cur_res;
          snap_gp = gen_period;
        end
      end else begin
        stalled = 1'b0;
      end

      // drive the sample for the coming edge and fold it into the model
      in_win = active && (k >= SC) && (k < SC + win);
      if (in_win) begin
        idx = k - SC;
        case (mode)
          0: begin
            sample_valid = ($urandom_range(0, 9) < 7);
            sample_in    = WW'($urandom);
          end
          1: begin
            sample_valid = (idx < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (idx == 0)      sample_in = WW'(1000);
            else if (idx == 1) sample_in = WW'(-1000);
            else               sample_in = WW'(int'($urandom_range(0, 2000)) - 1000);
          end
          2: begin
            sample_valid = 1'b0;
            sample_in    = WW'($urandom);
          end
          default: begin
            sample_valid = 1'b1;
            sample_in    = (idx % 2 == 1) ? WW'(32767) : WW'(-32768);
          end
        endcase
      end else begin
        sample_valid = 1'($urandom_range(0, 1));
        sample_in    = WW'($urandom);
      end
      if (in_win && sample_valid) begin
        v = sample_in;
        if (!any || v < tmin) tmin = v;
        if (!any || v > tmax) tmax = v;
        any = 1'b1;
      end
      if (active && k == SC + win - 1) begin
        if (any) exp_q.push_back({PW'(cur_p), WW'(tmin), WW'(tmax), (WW+1)'(tmax - tmin), 1'b0});
        else     exp_q.push_back({PW'(cur_p), {(3*WW+1){1'b0}}, 1'b1});
      end
      if (active) k++;
      prev_gr = gen_run;
      prev_rv = res_if.result_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_gen_run"}, gen_run, 0);
    check({tag, "_gen_period"}, gen_period, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, res_if.result_valid, 0);
    check({tag, "_result"}, {res_if.result_period, res_if.result_min, res_if.result_max,
                            res_if.result_p2p, res_if.result_empty}, 0);
  endtask

  task automatic launch_sweep(input int s, input int st, input int sp, input int m, input int rm);
    mode         = m;
    ready_mode   = rm;
    plan_sweep(s, st, sp);
    period_start = PW'(s);
    period_step  = PW'(st);
    period_stop  = PW'(sp);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("gen_run_after_start", gen_run, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", limit);
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!res_if.result_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!res_if.result_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: result_valid still 0 after %0d cycles, expected 1", limit);
    end
  endtask

  task automatic finish_sweep(input int d0);
    wait_idle(60000);
    check("done_pulses", done_cnt - d0, 1);
    check("results_left", exp_q.size(), 0);
    check("points_left", per_q.size(), 0);
    check("gen_run_idle", gen_run, 0);
  endtask

  task automatic run_sweep(input int s, input int st, input int sp, input int m, input int rm);
    int d0;
    d0 = done_cnt;
    launch_sweep(s, st, sp, m, rm);
    finish_sweep(d0);
  endtask

  task automatic reset_pulse(input string tag);
    int d0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(tag);
    exp_q.delete();
    per_q.delete();
    rst = 1'b0;
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    check({tag, "_no_done"}, done_cnt - d0, 0);
    check({tag, "_stays_idle"}, busy, 0);
  endtask

  // ---------------- main sequence ----------------
  int d_bp;

  initial begin
    res_if.result_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // periods 5,10,15 with a bounded +-1000 response
    run_sweep(5, 5, 15, 1, 0);
    // random response under random backpressure
    run_sweep(1, 2, 4, 0, 1);
    // start above stop: one point, held 500 cycles in report
    d_bp = done_cnt;
    launch_sweep(3, 1, 1, 0, 2);
    wait_valid(20000);
    repeat (500) @(negedge clk);
    check("stall_still_valid", res_if.result_valid, 1);
    ready_mode = 0;
    finish_sweep(d_bp);
    // no valid samples -> empty result
    run_sweep(1, 0, 1, 2, 0);
    // zero start treated as 1, full-scale extremes
    run_sweep(0, 1, 0, 3, 0);
    // next period overflows the period width
    run_sweep(1, 255, 255, 1, 0);

    // reset in the middle of a measurement window
    launch_sweep(2, 1, 3, 0, 0);
    repeat (SC + 700) @(negedge clk);
    reset_pulse("rst_measure");

    // reset while a result waits in report
    launch_sweep(1, 1, 2, 1, 2);
    wait_valid(20000);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_report");
    exp_q.delete();
    per_q.delete();
    rst = 1'b0;
    // fresh sweep starts on the first clock after reset release
    run_sweep(2, 1, 3, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
